// File: rtl/histogram_denetleyici.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_denetleyici
//  Purpose  : Run sequencer for the 256-bin histogram engine. Clears the
//             engine, streams a frame of pixels from image RAM through a
//             valid/ready handshake, copies the 256 result words into the
//             result RAM and checks bin order and total count.
//  Revision : 1.0  initial release
// ============================================================================
module histogram_denetleyici #(
    parameter int PIKSEL_SAYISI = 76800,
    parameter int ADR_W         = 17,
    parameter int ZAMAN_ASIMI   = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             baslat_i,
    output logic             mesgul_o,
    output logic             bitti_o,
    output logic             hata_o,
    output logic             mem_oku_o,
    output logic [ADR_W-1:0] mem_adr_o,
    input  logic [7:0]       mem_veri_i,
    output logic             hist_temizle_o,
    output logic [7:0]       hist_veri_o,
    output logic             hist_gecerli_o,
    input  logic             hist_hazir_i,
    output logic             hist_oku_o,
    input  logic [31:0]      hist_sonuc_i,
    input  logic             hist_sonuc_gecerli_i,
    output logic             sonuc_yaz_o,
    output logic [7:0]       sonuc_adr_o,
    output logic [31:0]      sonuc_veri_o
);

    // Timeout counter only has to reach ZAMAN_ASIMI-1.
    localparam int                c_ZA_W       = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
    localparam logic [c_ZA_W-1:0] c_ZA_SON     = c_ZA_W'(ZAMAN_ASIMI - 1);
    localparam logic [ADR_W-1:0]  c_PIKSEL_SON = ADR_W'(PIKSEL_SAYISI - 1);
    localparam logic [31:0]       c_TOPLAM     = 32'(PIKSEL_SAYISI);

    typedef enum logic [2:0] {
        BOSTA   = 3'd0,
        TEMIZLE = 3'd1,
        OKU     = 3'd2,
        BEKLE   = 3'd3,
        GONDER  = 3'd4,
        TOPLA   = 3'd5,
        KONTROL = 3'd6,
        BITTI   = 3'd7
    } durum_t;

    durum_t              r_durum;
    durum_t              w_durum_sonraki;

    logic [ADR_W-1:0]    r_piksel;
    logic [8:0]          r_bin;
    logic [31:0]         r_toplam;
    logic [c_ZA_W-1:0]   r_zaman;
    logic                r_hata;
    logic [7:0]          r_hist_veri;
    logic                r_hist_gecerli;
    logic                r_sonuc_yaz;
    logic [7:0]          r_sonuc_adr;
    logic [31:0]         r_sonuc_veri;

    logic                w_el_sikisma;
    logic                w_sonuc_al;
    logic                w_zaman_doldu;
    logic [8:0]          w_bin_art;

    // Progress events: a pixel accepted in GONDER, a result word taken in TOPLA.
    assign w_el_sikisma  = (r_durum == GONDER) && r_hist_gecerli && hist_hazir_i;
    assign w_sonuc_al    = (r_durum == TOPLA) && hist_sonuc_gecerli_i;
    assign w_zaman_doldu = (r_zaman == c_ZA_SON);
    // Bit 8 of the incremented bin counter marks the 256th word.
    assign w_bin_art     = r_bin + 9'd1;

    assign mesgul_o       = (r_durum != BOSTA);
    assign bitti_o        = (r_durum == BITTI);
    assign hata_o         = r_hata;
    assign mem_oku_o      = (r_durum == OKU);
    // Address is gated so the counter's final value never appears on the bus.
    assign mem_adr_o      = (r_durum == OKU) ? r_piksel : '0;
    assign hist_temizle_o = (r_durum == TEMIZLE);
    assign hist_veri_o    = r_hist_veri;
    assign hist_gecerli_o = r_hist_gecerli;
    assign hist_oku_o     = (r_durum == TOPLA);
    assign sonuc_yaz_o    = r_sonuc_yaz;
    assign sonuc_adr_o    = r_sonuc_adr;
    assign sonuc_veri_o   = r_sonuc_veri;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_durum_sonraki;
        end
    end

    // Next-state decode; a handshake or result word beats a timeout in the same cycle.
    always_comb begin
        w_durum_sonraki = r_durum;
        case (r_durum)
            BOSTA:   if (baslat_i) w_durum_sonraki = TEMIZLE;
            TEMIZLE: w_durum_sonraki = OKU;
            OKU:     w_durum_sonraki = BEKLE;
            BEKLE:   w_durum_sonraki = GONDER;
            GONDER: begin
                if (w_el_sikisma) begin
                    w_durum_sonraki = (r_piksel == c_PIKSEL_SON) ? TOPLA : OKU;
                end else if (w_zaman_doldu) begin
                    w_durum_sonraki = BITTI;
                end
            end
            TOPLA: begin
                if (w_sonuc_al) begin
                    if (w_bin_art[8]) w_durum_sonraki = KONTROL;
                end else if (w_zaman_doldu) begin
                    w_durum_sonraki = BITTI;
                end
            end
            KONTROL: w_durum_sonraki = BITTI;
            BITTI:   w_durum_sonraki = BOSTA;
            default: w_durum_sonraki = BOSTA;
        endcase
    end

    // Datapath: counters, pixel holding register, result write port and error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_piksel       <= '0;
            r_bin          <= '0;
            r_toplam       <= '0;
            r_zaman        <= '0;
            r_hata         <= 1'b0;
            r_hist_veri    <= '0;
            r_hist_gecerli <= 1'b0;
            r_sonuc_yaz    <= 1'b0;
            r_sonuc_adr    <= '0;
            r_sonuc_veri   <= '0;
        end else begin
            r_sonuc_yaz <= w_sonuc_al;
            if (w_sonuc_al) begin
                r_sonuc_adr  <= r_bin[7:0];
                r_sonuc_veri <= hist_sonuc_i;
            end

            case (r_durum)
                BOSTA: begin
                    if (baslat_i) begin
                        r_hata   <= 1'b0;
                        r_piksel <= '0;
                        r_bin    <= '0;
                        r_toplam <= '0;
                        r_zaman  <= '0;
                    end
                end
                BEKLE: begin
                    r_hist_veri    <= mem_veri_i;
                    r_hist_gecerli <= 1'b1;
                end
                GONDER: begin
                    if (w_el_sikisma) begin
                        r_hist_gecerli <= 1'b0;
                        r_piksel       <= r_piksel + 1'b1;
                        r_zaman        <= '0;
                    end else if (w_zaman_doldu) begin
                        r_hata         <= 1'b1;
                        r_hist_gecerli <= 1'b0;
                    end else begin
                        r_zaman <= r_zaman + 1'b1;
                    end
                end
                TOPLA: begin
                    if (w_sonuc_al) begin
                        r_toplam <= r_toplam + {8'd0, hist_sonuc_i[23:0]};
                        // Out-of-order index flags an error; the word is still stored.
                        if (hist_sonuc_i[31:24] != r_bin[7:0]) r_hata <= 1'b1;
                        r_bin   <= w_bin_art;
                        r_zaman <= '0;
                    end else if (w_zaman_doldu) begin
                        r_hata <= 1'b1;
                    end else begin
                        r_zaman <= r_zaman + 1'b1;
                    end
                end
                KONTROL: begin
                    if (r_toplam != c_TOPLAM) r_hata <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_histogram_denetleyici.sv
`default_nettype none
// ============================================================================
//  Module   : tb_histogram_denetleyici
//  Purpose  : Self-checking bench for histogram_denetleyici with a small
//             frame, an image RAM model and a histogram engine model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_histogram_denetleyici;

    localparam int N_PIX = 16;
    localparam int AW    = 4;
    localparam int ZA    = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          baslat_i;
    logic          mesgul_o, bitti_o, hata_o;
    logic          mem_oku_o;
    logic [AW-1:0] mem_adr_o;
    logic [7:0]    mem_veri_i;
    logic          hist_temizle_o;
    logic [7:0]    hist_veri_o;
    logic          hist_gecerli_o;
    logic          hist_hazir_i;
    logic          hist_oku_o;
    logic [31:0]   hist_sonuc_i;
    logic          hist_sonuc_gecerli_i;
    logic          sonuc_yaz_o;
    logic [7:0]    sonuc_adr_o;
    logic [31:0]   sonuc_veri_o;

    histogram_denetleyici #(
        .PIKSEL_SAYISI(N_PIX),
        .ADR_W        (AW),
        .ZAMAN_ASIMI  (ZA)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .baslat_i            (baslat_i),
        .mesgul_o            (mesgul_o),
        .bitti_o             (bitti_o),
        .hata_o              (hata_o),
        .mem_oku_o           (mem_oku_o),
        .mem_adr_o           (mem_adr_o),
        .mem_veri_i          (mem_veri_i),
        .hist_temizle_o      (hist_temizle_o),
        .hist_veri_o         (hist_veri_o),
        .hist_gecerli_o      (hist_gecerli_o),
        .hist_hazir_i        (hist_hazir_i),
        .hist_oku_o          (hist_oku_o),
        .hist_sonuc_i        (hist_sonuc_i),
        .hist_sonuc_gecerli_i(hist_sonuc_gecerli_i),
        .sonuc_yaz_o         (sonuc_yaz_o),
        .sonuc_adr_o         (sonuc_adr_o),
        .sonuc_veri_o        (sonuc_veri_o)
    );

    always #5 clk = ~clk;

    // ---------------- configuration driven by the test ----------------
    logic [7:0] ram [N_PIX];
    bit cfg_stall = 1'b0, cfg_hold0 = 1'b0, cfg_bad_idx = 1'b0, cfg_bad_sum = 1'b0;

    // ---------------- image RAM model: one-cycle read latency ----------------
    always @(posedge clk) begin
        if (mem_oku_o) mem_veri_i <= ram[mem_adr_o];
    end

    // ---------------- histogram engine model ----------------
    int   hist [256];
    int   n_acc = 0;
    int   idx = 0;
    int   stall_left = 0;
    logic hazir_r = 1'b1;

    assign hist_hazir_i = hazir_r && !(cfg_hold0 && n_acc == 5);

    function automatic logic [31:0] eng_word(input int k);
        logic [7:0]  ix;
        logic [23:0] cnt;
        ix  = 8'(k);
        cnt = (k < 256) ? 24'(hist[k]) : 24'd0;
        if (cfg_bad_idx && k == 7) ix = 8'h08;
        if (cfg_bad_sum && k == 0) cnt = cnt - 24'd1;
        return {ix, cnt};
    endfunction

    always @(posedge clk) begin : eng
        int idx_n;
        int r;
        if (rst_i) begin
            idx                  <= 0;
            hist_sonuc_gecerli_i <= 1'b0;
            hist_sonuc_i         <= '0;
            hazir_r              <= 1'b1;
            stall_left           <= 0;
        end else begin
            if (hist_gecerli_o && hist_hazir_i) begin
                hist[hist_veri_o] <= hist[hist_veri_o] + 1;
                n_acc             <= n_acc + 1;
                if (cfg_stall) begin
                    r          = int'($urandom_range(0, 5));
                    stall_left <= r;
                    hazir_r    <= (r == 0);
                end
            end else if (cfg_stall && hist_gecerli_o && !hazir_r) begin
                stall_left <= stall_left - 1;
                hazir_r    <= (stall_left == 1);
            end
            idx_n = (hist_sonuc_gecerli_i && hist_oku_o) ? idx + 1 : idx;
            idx                  <= idx_n;
            hist_sonuc_gecerli_i <= hist_oku_o && (idx_n < 256);
            hist_sonuc_i         <= eng_word(idx_n);
            if (hist_temizle_o) begin
                for (int k = 0; k < 256; k++) hist[k] <= 0;
                n_acc      <= 0;
                idx        <= 0;
                hazir_r    <= 1'b1;
                stall_left <= 0;
            end
        end
    end

    // ---------------- output monitor (negedge) ----------------
    logic [31:0] res_ram [256];
    int   cyc = 0, rd_n = 0, wr_n = 0, bitti_cnt = 0, viol = 0;
    int   bitti_cyc = 0, gonder_cyc = 0;
    int   rd_adr [32];
    int   rd_cyc [32];
    logic p_gec = 1'b0, p_hazir = 1'b0;
    logic [7:0] p_veri = 8'd0;

    always @(negedge clk) begin
        cyc++;
        if (hist_temizle_o) begin
            rd_n = 0; wr_n = 0; bitti_cnt = 0; viol = 0;
            for (int k = 0; k < 256; k++) res_ram[k] = 32'hDEADBEEF;
        end
        if (mem_oku_o) begin
            if (rd_n < 32) begin
                rd_adr[rd_n] = int'(mem_adr_o);
                rd_cyc[rd_n] = cyc;
            end
            rd_n++;
        end
        if (sonuc_yaz_o) begin
            res_ram[sonuc_adr_o] = sonuc_veri_o;
            wr_n++;
        end
        if (bitti_o) begin
            bitti_cnt++;
            bitti_cyc = cyc;
        end
        if (hist_gecerli_o && !p_gec) gonder_cyc = cyc;
        if (hist_gecerli_o && p_gec && !p_hazir && hist_veri_o != p_veri) viol++;
        p_gec   = hist_gecerli_o;
        p_hazir = hist_hazir_i;
        p_veri  = hist_veri_o;
    end

    logic [59:0] o_all;
    assign o_all = {mesgul_o, bitti_o, hata_o, mem_oku_o, mem_adr_o, hist_temizle_o,
                    hist_veri_o, hist_gecerli_o, hist_oku_o, sonuc_yaz_o, sonuc_adr_o,
                    sonuc_veri_o};

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] exp_word(input int k);
        int cnt;
        logic [7:0] ix;
        cnt = 0;
        for (int j = 0; j < N_PIX; j++) if (int'(ram[j]) == k) cnt++;
        if (cfg_bad_sum && k == 0) cnt--;
        ix = (cfg_bad_idx && k == 7) ? 8'h08 : 8'(k);
        return {ix, 24'(cnt)};
    endfunction

    typedef struct {
        bit          ff;
        bit          stall;
        bit          bad_idx;
        bit          bad_sum;
        bit          hold0;
        bit          bas_topla;
        bit          exp_hata;
        int          exp_wr;
        int          exp_rd;
        logic [31:0] exp_w7;
        logic [31:0] exp_w255;
    } vec_t;

    vec_t vt [6];

    task automatic wait_bitti(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (bitti_o) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int i);
        bit seen, pulsed;
        int bad;
        for (int k = 0; k < N_PIX; k++) ram[k] = v.ff ? 8'hFF : 8'(k);
        cfg_stall = v.stall; cfg_hold0 = v.hold0;
        cfg_bad_idx = v.bad_idx; cfg_bad_sum = v.bad_sum;
        baslat_i = 1'b1;
        @(negedge clk);
        baslat_i = 1'b0;
        seen = 1'b0; pulsed = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (bitti_o) seen = 1'b1;
            else if (v.bas_topla && !pulsed && hist_oku_o) begin
                baslat_i = 1'b1; pulsed = 1'b1;
            end else baslat_i = 1'b0;
        end
        baslat_i = 1'b0;
        chk($sformatf("v%0d_bitti_seen", i), 64'(seen), 64'(1));
        @(negedge clk);
        chk($sformatf("v%0d_mesgul_after", i), 64'(mesgul_o), 64'(0));
        chk($sformatf("v%0d_hata", i), 64'(hata_o), 64'(v.exp_hata));
        repeat (8) @(negedge clk);
        chk($sformatf("v%0d_bitti_count", i), 64'(bitti_cnt), 64'(1));
        chk($sformatf("v%0d_no_restart", i), 64'(mesgul_o), 64'(0));
        chk($sformatf("v%0d_writes", i), 64'(wr_n), 64'(v.exp_wr));
        chk($sformatf("v%0d_reads", i), 64'(rd_n), 64'(v.exp_rd));
        chk($sformatf("v%0d_word7", i), 64'(res_ram[7]), 64'(v.exp_w7));
        chk($sformatf("v%0d_word255", i), 64'(res_ram[255]), 64'(v.exp_w255));
        chk($sformatf("v%0d_veri_stable", i), 64'(viol), 64'(0));
        bad = 0;
        for (int j = 0; j < rd_n && j < 32; j++) begin
            if (rd_adr[j] != j) bad++;
            if (!v.stall && j > 0 && rd_cyc[j] - rd_cyc[j-1] != 3) bad++;
        end
        chk($sformatf("v%0d_read_seq", i), 64'(bad), 64'(0));
        if (v.exp_wr == 256) begin
            bad = 0;
            for (int k = 0; k < 256; k++) if (res_ram[k] !== exp_word(k)) bad++;
            chk($sformatf("v%0d_ram_contents", i), 64'(bad), 64'(0));
        end
        if (v.hold0) chk($sformatf("v%0d_timeout_latency", i), 64'(bitti_cyc - gonder_cyc), 64'(8));
    endtask

    initial begin
        bit seen;
        rst_i = 1'b1; baslat_i = 1'b0;
        for (int k = 0; k < N_PIX; k++) ram[k] = 8'(k);

        //        ff    stall bidx  bsum  hold0 btop  hata  wr   rd  word7          word255
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 256, 16, 32'h07000001, 32'hFF000000};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 256, 16, 32'h07000000, 32'hFF000010};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 256, 16, 32'h08000001, 32'hFF000000};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 256, 16, 32'h07000001, 32'hFF000000};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 256, 16, 32'h07000001, 32'hFF000000};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0,   6,  32'hDEADBEEF, 32'hDEADBEEF};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(o_all), 64'(0));
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_mesgul", 64'(mesgul_o), 64'(0));

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Restart after the timeout run: error flag clears on the accepted start.
        cfg_hold0 = 1'b0;
        baslat_i = 1'b1;
        @(negedge clk);
        baslat_i = 1'b0;
        chk("restart_hata_clear", 64'(hata_o), 64'(0));
        chk("restart_mesgul", 64'(mesgul_o), 64'(1));
        wait_bitti(seen);
        chk("restart_bitti_seen", 64'(seen), 64'(1));
        @(negedge clk);
        chk("restart_hata_end", 64'(hata_o), 64'(0));

        // Reset mid-GONDER at pixel 9, then restart from address 0.
        repeat (3) @(negedge clk);
        baslat_i = 1'b1;
        @(negedge clk);
        baslat_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (hist_gecerli_o && n_acc == 9) seen = 1'b1;
        end
        chk("midrst_reached_pix9", 64'(seen), 64'(1));
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("midrst_outputs", 64'(o_all), 64'(0));
        repeat (5) @(negedge clk);
        chk("midrst_no_bitti", 64'(bitti_cnt), 64'(0));
        chk("midrst_idle", 64'(mesgul_o), 64'(0));
        baslat_i = 1'b1;
        @(negedge clk);
        baslat_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (mem_oku_o) seen = 1'b1;
        end
        chk("midrst_first_read_seen", 64'(seen), 64'(1));
        chk("midrst_first_addr", 64'(mem_adr_o), 64'(0));
        wait_bitti(seen);
        chk("midrst_bitti_seen", 64'(seen), 64'(1));
        repeat (3) @(negedge clk);
        chk("midrst_hata", 64'(hata_o), 64'(0));
        chk("midrst_writes", 64'(wr_n), 64'(256));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
